// File: rtl/twi_word_deserializer.sv
// Serial-to-parallel TWI word assembler with a DEPTH-entry valid/ready output FIFO.
// Define TWI_DESER_ACK_EN to capture the trailing ACK slot of each word into out_ack.
module twi_word_deserializer #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     bit_valid,
   input  logic                     bit_in,
   input  logic                     msb_first,
   input  logic                     frame_sync,
   output logic [WIDTH-1:0]         out_data,
   output logic                     out_ack,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overflow,
   output logic                     partial
);

`ifdef TWI_DESER_ACK_EN
   localparam int L = WIDTH + 1;
`else
   localparam int L = WIDTH;
`endif
   localparam int CW = $clog2(L);
   localparam int AW = $clog2(DEPTH);
   localparam logic [CW-1:0] LAST = CW'(L - 1);
   localparam logic [AW:0]   FULL_LEVEL = (AW + 1)'(DEPTH);

   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] sr;
   logic [WIDTH-1:0] sr_next;
   logic             order_hold;
   logic             order;
   logic             take;
   logic             data_slot;
   logic             done;
   logic [WIDTH-1:0] word;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             full;
   logic             pop;
   logic             accept;

   // The first bit of a word uses msb_first directly; later bits use the held copy.
   always_comb begin
      order   = (cnt == '0) ? msb_first : order_hold;
      take    = bit_valid && !frame_sync;
      sr_next = order ? {sr[WIDTH-2:0], bit_in} : {bit_in, sr[WIDTH-1:1]};
      done    = take && (cnt == LAST);
`ifdef TWI_DESER_ACK_EN
      data_slot = (cnt != CW'(WIDTH));
      word      = sr;
`else
      data_slot = 1'b1;
      word      = sr_next;
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt        <= '0;
         sr         <= '0;
         order_hold <= 1'b0;
         partial    <= 1'b0;
      end else begin
         partial <= 1'b0;
         if (frame_sync) begin
            cnt     <= '0;
            sr      <= '0;
            partial <= (cnt != '0);
         end else if (bit_valid) begin
            if (cnt == '0) order_hold <= msb_first;
            if (data_slot) sr <= sr_next;
            cnt <= done ? '0 : cnt + CW'(1);
         end
      end
   end

   always_comb begin
      full      = (level == FULL_LEVEL);
      out_valid = (level != '0);
      pop       = out_valid && out_ready;
      accept    = done && (!full || pop);
      out_data  = mem[rd_ptr];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mem      <= '{default: '0};
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         overflow <= 1'b0;
      end else begin
         if (accept) begin
            mem[wr_ptr] <= word;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         if (done && full && !pop) overflow <= 1'b1;
         case ({accept, pop})
            2'b10:   level <= level + (AW + 1)'(1);
            2'b01:   level <= level - (AW + 1)'(1);
            default: level <= level;
         endcase
      end
   end

`ifdef TWI_DESER_ACK_EN
   logic ack_mem [DEPTH];

   // SDA low in the ACK slot means acknowledged.
   always_ff @(posedge clk) begin
      if (reset) begin
         ack_mem <= '{default: 1'b0};
      end else if (accept) begin
         ack_mem[wr_ptr] <= ~bit_in;
      end
   end

   assign out_ack = ack_mem[rd_ptr];
`else
   assign out_ack = 1'b0;
`endif

endmodule

// File: tb/tb_twi_word_deserializer.sv
// Scoreboard bench for twi_word_deserializer; covers the ACK slot when TWI_DESER_ACK_EN is defined.
module tb_twi_word_deserializer;
   localparam int WIDTH = 8;
   localparam int DEPTH = 4;
`ifdef TWI_DESER_ACK_EN
   localparam int L = WIDTH + 1;
`else
   localparam int L = WIDTH;
`endif

   logic                   clk = 1'b0;
   logic                   reset = 1'b1;
   logic                   bit_valid = 1'b0;
   logic                   bit_in = 1'b0;
   logic                   msb_first = 1'b1;
   logic                   frame_sync = 1'b0;
   logic [WIDTH-1:0]       out_data;
   logic                   out_ack;
   logic                   out_valid;
   logic                   out_ready = 1'b0;
   logic [$clog2(DEPTH):0] level;
   logic                   overflow;
   logic                   partial;

   twi_word_deserializer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .bit_valid(bit_valid), .bit_in(bit_in),
      .msb_first(msb_first), .frame_sync(frame_sync), .out_data(out_data),
      .out_ack(out_ack), .out_valid(out_valid), .out_ready(out_ready),
      .level(level), .overflow(overflow), .partial(partial)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Bench reference state
   logic [WIDTH:0]   q[$];
   int               mcnt = 0;
   logic             morder = 1'b1;
   logic [WIDTH-1:0] mword = '0;
   logic             mack = 1'b0;
   logic             exp_ovf = 1'b0;
   int               exp_part = 0;
   int               pulses = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         if (partial) pulses++;
         check("valid_vs_model", {31'd0, out_valid}, {31'd0, (q.size() != 0)});
         check("level_vs_model", 32'(level), 32'(q.size()));
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               check("pop_with_empty_model", 32'd1, 32'd0);
            end else begin
               logic [WIDTH:0] e;
               e = q.pop_front();
               check("pop_data", 32'(out_data), 32'(e[WIDTH-1:0]));
               check("pop_ack", {31'd0, out_ack}, {31'd0, e[WIDTH]});
            end
         end
      end
   end

   task automatic model_bit(input logic b);
      if (mcnt == 0) morder = msb_first;
      if (mcnt < WIDTH) begin
         if (morder) mword[WIDTH-1-mcnt] = b;
         else        mword[mcnt] = b;
      end else begin
         mack = ~b;
      end
      if (mcnt == L - 1) begin
         if (q.size() < DEPTH) q.push_back({mack, mword});
         else                  exp_ovf = 1'b1;
         mcnt = 0;
         mword = '0;
         mack = 1'b0;
      end else begin
         mcnt++;
      end
   endtask

   task automatic send_bit(input logic b, input int gap, input bit rdy);
      @(posedge clk);
      #1;
      bit_valid = 1'b1;
      bit_in = b;
      if (rdy) out_ready = 1'b1;
      @(posedge clk);
      model_bit(b);
      #1;
      bit_valid = 1'b0;
      if (rdy) out_ready = 1'b0;
      repeat (gap) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_word(input logic [WIDTH-1:0] w, input logic msb, input bit toggle,
                            input int gap, input logic ackb, input bit ready_last);
      bit last;
      msb_first = msb;
      for (int i = 0; i < WIDTH; i++) begin
         last = (i == WIDTH - 1) && (L == WIDTH);
         send_bit(msb ? w[WIDTH-1-i] : w[i], last ? 0 : gap, last && ready_last);
         if (toggle && i == 0) msb_first = ~msb;
      end
`ifdef TWI_DESER_ACK_EN
      send_bit(ackb, 0, ready_last);
`else
      if (ackb) begin end
`endif
   endtask

   task automatic fsync(input logic with_bit);
      @(posedge clk);
      #1;
      frame_sync = 1'b1;
      bit_valid = with_bit;
      bit_in = 1'b1;
      @(posedge clk);
      if (mcnt != 0) exp_part++;
      mcnt = 0;
      mword = '0;
      mack = 1'b0;
      #1;
      frame_sync = 1'b0;
      bit_valid = 1'b0;
   endtask

   task automatic drain(input int n);
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      repeat (n) @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      reset = 1'b1;
      q.delete();
      mcnt = 0;
      mword = '0;
      mack = 1'b0;
      exp_ovf = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      check("rst_valid", {31'd0, out_valid}, 32'd0);
      check("rst_level", 32'(level), 32'd0);
      check("rst_data", 32'(out_data), 32'd0);
      check("rst_ack", {31'd0, out_ack}, 32'd0);
      check("rst_ovf", {31'd0, overflow}, 32'd0);
      check("rst_partial", {31'd0, partial}, 32'd0);

      // Test 1: 0xA5 MSB first, one idle cycle between bits
      send_word(8'hA5, 1'b1, 1'b0, 0, 1'b1, 1'b0);
      check("t1_valid", {31'd0, out_valid}, 32'd1);
      check("t1_data", 32'(out_data), 32'hA5);
      check("t1_level", 32'(level), 32'd1);
      check("t1_partial", {31'd0, partial}, 32'd0);
      drain(2);

      // Test 2: bit order and mid-word toggle
      send_word(8'h03, 1'b0, 1'b0, 1, 1'b1, 1'b0);
      check("t2_lsb", 32'(out_data), 32'h03);
      drain(2);
      send_word(8'hC0, 1'b1, 1'b0, 0, 1'b1, 1'b0);
      check("t2_msb", 32'(out_data), 32'hC0);
      drain(2);
      send_word(8'hC0, 1'b1, 1'b1, 0, 1'b1, 1'b0);
      check("t2_toggle", 32'(out_data), 32'hC0);
      drain(2);

      // Test 3: overflow with stalled consumer
      send_word(8'h11, 1'b1, 1'b0, 0, 1'b1, 1'b0);
      send_word(8'h22, 1'b0, 1'b0, 2, 1'b1, 1'b0);
      send_word(8'h33, 1'b1, 1'b0, 0, 1'b1, 1'b0);
      send_word(8'h44, 1'b0, 1'b0, 0, 1'b1, 1'b0);
      send_word(8'h55, 1'b1, 1'b0, 0, 1'b1, 1'b0);
      check("t3_level", 32'(level), 32'd4);
      check("t3_ovf", {31'd0, overflow}, 32'd1);
      check("t3_head", 32'(out_data), 32'h11);
      drain(6);
      check("t3_empty_valid", {31'd0, out_valid}, 32'd0);
      check("t3_empty_level", 32'(level), 32'd0);
      check("t3_ovf_sticky", {31'd0, overflow}, {31'd0, exp_ovf});

      // Test 4: resynchronisation on frame_sync
      send_bit(1'b1, 0, 1'b0);
      send_bit(1'b0, 0, 1'b0);
      send_bit(1'b1, 0, 1'b0);
      fsync(1'b0);
      repeat (2) @(posedge clk);
      #1;
      check("t4_partial_once", 32'(pulses), 32'(exp_part));
      check("t4_partial_count", 32'(exp_part), 32'd1);
      send_word(8'h3C, 1'b1, 1'b0, 0, 1'b1, 1'b0);
      check("t4_data", 32'(out_data), 32'h3C);
      fsync(1'b0);
      repeat (2) @(posedge clk);
      #1;
      check("t4_no_partial_at_zero", 32'(pulses), 32'd1);
      // frame_sync together with bit_valid: the bit is dropped
      send_bit(1'b0, 0, 1'b0);
      send_bit(1'b1, 0, 1'b0);
      fsync(1'b1);
      send_word(8'h96, 1'b1, 1'b0, 0, 1'b1, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      check("t4_sync_with_bit", 32'(pulses), 32'd2);
      drain(3);

      // Random words with the consumer always ready
      out_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         send_word(WIDTH'($urandom), 1'($urandom), 1'b0, $urandom_range(0, 2), 1'($urandom), 1'b0);
      end
      repeat (3) @(posedge clk);
      #1;
      out_ready = 1'b0;

      // Reset mid-word with a non-empty FIFO
      send_word(8'h77, 1'b1, 1'b0, 0, 1'b1, 1'b0);
      send_bit(1'b1, 0, 1'b0);
      send_bit(1'b1, 0, 1'b0);
      do_reset();
      repeat (2) @(posedge clk);
      #1;
      check("rst2_level", 32'(level), 32'd0);
      check("rst2_valid", {31'd0, out_valid}, 32'd0);
      check("rst2_data", 32'(out_data), 32'd0);
      check("rst2_ovf", {31'd0, overflow}, 32'd0);
      check("rst2_no_partial", 32'(pulses), 32'd2);

      // Test 5: push and pop together while full
      send_word(8'h11, 1'b1, 1'b0, 0, 1'b1, 1'b0);
      send_word(8'h22, 1'b1, 1'b0, 0, 1'b1, 1'b0);
      send_word(8'h33, 1'b1, 1'b0, 0, 1'b1, 1'b0);
      send_word(8'h44, 1'b1, 1'b0, 0, 1'b1, 1'b0);
      send_word(8'h55, 1'b1, 1'b0, 0, 1'b1, 1'b1);
      check("t5_ovf", {31'd0, overflow}, 32'd0);
      check("t5_level", 32'(level), 32'd4);
      check("t5_head", 32'(out_data), 32'h22);
      drain(6);
      check("t5_empty", 32'(level), 32'd0);

`ifdef TWI_DESER_ACK_EN
      // Test 6: ACK slot capture
      send_word(8'h5A, 1'b1, 1'b0, 0, 1'b0, 1'b0);
      check("t6_data", 32'(out_data), 32'h5A);
      check("t6_ack", {31'd0, out_ack}, 32'd1);
      drain(2);
      send_word(8'hFF, 1'b0, 1'b0, 0, 1'b1, 1'b0);
      check("t6_data_nack", 32'(out_data), 32'hFF);
      check("t6_nack", {31'd0, out_ack}, 32'd0);
      drain(2);
`endif

      check("final_queue_empty", 32'(q.size()), 32'd0);
      check("final_ovf", {31'd0, overflow}, {31'd0, exp_ovf});
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
